// File: rtl/nco_phase_gen.sv
// Phase accumulator with static offset and a linear fcw sweep FSM, driving the CORDIC phase input.
// Optional truncation dither is enabled by defining PHASE_DITHER_EN.
module nco_phase_gen #(
    parameter int pha_width = 16,
    parameter int acc_width = 32,
    parameter int len_width = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 ena,
    input  logic                 clr,
    input  logic [acc_width-1:0] fcw_in,
    input  logic                 fcw_valid,
    output logic                 fcw_ready,
    input  logic [pha_width-1:0] pho_in,
    input  logic                 sweep_start,
    input  logic [acc_width-1:0] sweep_step,
    input  logic [len_width-1:0] sweep_len,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [pha_width-1:0] phase_out,
    output logic                 phase_valid,
    output logic [1:0]           sweep_state
);

    localparam int frac_width = acc_width - pha_width;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [len_width-1:0]   cnt, cnt_nxt;
    logic [acc_width-1:0]   fcw_cur, fcw_nxt;
    logic [acc_width-1:0]   acc;
    logic [acc_width-1:0]   acc_q;

    // fcw handshake: a word transfers on any rising edge where fcw_valid && fcw_ready;
    // fcw_ready is high only in IDLE, and the transfer does not depend on ena.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fcw_nxt     = fcw_cur;
        fcw_ready   = 1'b0;
        sweep_busy  = 1'b0;
        sweep_done  = 1'b0;
        case (state)
            IDLE: begin
                fcw_ready = 1'b1;
                if (fcw_valid) begin
                    fcw_nxt = fcw_in;
                end else if (ena && sweep_start && (sweep_len != '0)) begin
                    cnt_nxt   = sweep_len;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                sweep_busy = 1'b1;
                if (ena) begin
                    fcw_nxt = fcw_cur + sweep_step;
                    cnt_nxt = cnt - len_width'(1);
                    if (cnt == len_width'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sweep_state = state;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            fcw_cur <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fcw_cur <= fcw_nxt;
        end
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; its low bits round the accumulator into the output word.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 16'hACE1;
        end else if (ena) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign acc_q = acc + {{pha_width{1'b0}}, lfsr[frac_width-1:0]};
`else
    assign acc_q = acc;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= ena;
            if (clr) begin
                acc <= '0;
                if (ena) begin
                    phase_out <= pho_in;
                end
            end else if (ena) begin
                // Output uses the pre-update accumulator, giving a two-edge fcw-to-phase latency.
                phase_out <= acc_q[acc_width-1 -: pha_width] + pho_in;
                acc       <= acc + fcw_cur;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed-vector bench for nco_phase_gen (default build, pha_width=16, acc_width=32).
module tb_nco_phase_gen;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        ena, clr, fcw_valid, sweep_start;
    logic [31:0] fcw_in, sweep_step;
    logic [15:0] pho_in, sweep_len;
    logic        fcw_ready, sweep_busy, sweep_done, phase_valid;
    logic [15:0] phase_out;
    logic [1:0]  sweep_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    nco_phase_gen #(.pha_width(16), .acc_width(32), .len_width(16)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .ena(ena), .clr(clr),
        .fcw_in(fcw_in), .fcw_valid(fcw_valid), .fcw_ready(fcw_ready),
        .pho_in(pho_in), .sweep_start(sweep_start), .sweep_step(sweep_step),
        .sweep_len(sweep_len), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .phase_out(phase_out), .phase_valid(phase_valid), .sweep_state(sweep_state)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ena = 1'b0; clr = 1'b0; fcw_valid = 1'b0; sweep_start = 1'b0;
        fcw_in = '0; sweep_step = '0; pho_in = '0; sweep_len = '0;
        repeat (2) tick();
        vectors++;
        if ({phase_out, phase_valid, sweep_busy, sweep_done, fcw_ready, sweep_state} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            $display("FAIL reset: phase=%h valid=%b busy=%b done=%b ready=%b st=%0d, want 0000 0 0 0 1 0",
                     phase_out, phase_valid, sweep_busy, sweep_done, fcw_ready, sweep_state);
            miscompares++;
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_accumulate();
        logic [15:0] exp;
        fcw_in = 32'h0001_0000; fcw_valid = 1'b1; ena = 1'b1; pho_in = 16'h0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            fcw_valid = 1'b0;
            exp = (i <= 2) ? 16'h0 : 16'(i - 2);
            vectors++;
            if (phase_out !== exp || phase_valid !== 1'b1) begin
                $display("FAIL accumulate[%0d]: phase=%h valid=%b, want %h 1", i, phase_out, phase_valid, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_quadrant_wrap();
        logic [15:0] exp_tab [5];
        exp_tab = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
        fcw_in = 32'h4000_0000; fcw_valid = 1'b1; clr = 1'b1;
        tick();
        fcw_valid = 1'b0; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (phase_out !== exp_tab[i]) begin
                $display("FAIL quadrant[%0d]: phase=%h, want %h", i, phase_out, exp_tab[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_offset_clear();
        logic [15:0] exp_tab [3];
        fcw_in = 32'h0; fcw_valid = 1'b1; clr = 1'b1; pho_in = 16'h8000;
        tick();
        fcw_valid = 1'b0; clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (phase_out !== 16'h8000) begin
                $display("FAIL offset_const[%0d]: phase=%h, want 8000", i, phase_out);
                miscompares++;
            end
        end
        // Non-zero fcw so the clear has something to reset; fcw must survive it.
        fcw_in = 32'h1000_0000; fcw_valid = 1'b1;
        tick();
        fcw_valid = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_tab = '{16'h8000, 16'h8000, 16'h9000};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            vectors++;
            if (phase_out !== exp_tab[i]) begin
                $display("FAIL clr_midrun[%0d]: phase=%h, want %h", i, phase_out, exp_tab[i]);
                miscompares++;
            end
        end
        ena = 1'b0;
        tick();
        vectors++;
        if (phase_out !== 16'h9000 || phase_valid !== 1'b0) begin
            $display("FAIL ena_hold: phase=%h valid=%b, want 9000 0", phase_out, phase_valid);
            miscompares++;
        end
        ena = 1'b1;
    endtask

    task automatic test_sweep();
        logic [15:0] exp_ph [8];
        logic        exp_busy [8];
        logic        exp_done [8];
        logic        exp_rdy [8];
        exp_ph   = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd3, 16'd6, 16'd10, 16'd14};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        pho_in = 16'h0; fcw_in = 32'h0; fcw_valid = 1'b1; clr = 1'b1;
        tick();
        fcw_valid = 1'b0;
        sweep_step = 32'h0001_0000; sweep_len = 16'd4; sweep_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            sweep_start = 1'b0; clr = 1'b0;
            vectors++;
            if (phase_out !== exp_ph[i] || sweep_busy !== exp_busy[i] || sweep_done !== exp_done[i] || fcw_ready !== exp_rdy[i]) begin
                $display("FAIL sweep[%0d]: phase=%h busy=%b done=%b ready=%b, want %h %b %b %b", i,
                         phase_out, sweep_busy, sweep_done, fcw_ready, exp_ph[i], exp_busy[i], exp_done[i], exp_rdy[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_load_wins();
        fcw_in = 32'h2000_0000; fcw_valid = 1'b1; sweep_start = 1'b1; sweep_len = 16'd4; clr = 1'b1;
        tick();
        fcw_valid = 1'b0; sweep_start = 1'b0; clr = 1'b0;
        vectors++;
        if (sweep_busy !== 1'b0 || fcw_ready !== 1'b1) begin
            $display("FAIL load_wins_fsm: busy=%b ready=%b, want 0 1", sweep_busy, fcw_ready);
            miscompares++;
        end
        repeat (2) tick();
        vectors++;
        if (phase_out !== 16'h2000 || sweep_busy !== 1'b0) begin
            $display("FAIL load_wins_phase: phase=%h busy=%b, want 2000 0", phase_out, sweep_busy);
            miscompares++;
        end
    endtask

    task automatic test_sweep_freeze();
        int done_seen = 0;
        fcw_in = 32'h0; fcw_valid = 1'b1; clr = 1'b1;
        tick();
        fcw_valid = 1'b0;
        sweep_step = 32'h0001_0000; sweep_len = 16'd3; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0; clr = 1'b0;
        tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sweep_done) done_seen++;
            vectors++;
            if (sweep_busy !== 1'b1 || phase_valid !== 1'b0 || phase_out !== 16'h0) begin
                $display("FAIL freeze[%0d]: busy=%b valid=%b phase=%h, want 1 0 0000", i, sweep_busy, phase_valid, phase_out);
                miscompares++;
            end
        end
        ena = 1'b1;
        tick();
        vectors++;
        if (sweep_busy !== 1'b1 || sweep_done !== 1'b0 || done_seen != 0) begin
            $display("FAIL freeze_resume: busy=%b done=%b early_done=%0d, want 1 0 0", sweep_busy, sweep_done, done_seen);
            miscompares++;
        end
        tick();
        vectors++;
        if (sweep_done !== 1'b1 || phase_out !== 16'd1) begin
            $display("FAIL freeze_done: done=%b phase=%h, want 1 0001", sweep_done, phase_out);
            miscompares++;
        end
        tick();
        vectors++;
        if (sweep_done !== 1'b0 || phase_out !== 16'd3 || sweep_state !== 2'd0) begin
            $display("FAIL freeze_after: done=%b phase=%h st=%0d, want 0 0003 0", sweep_done, phase_out, sweep_state);
            miscompares++;
        end
    endtask

    task automatic test_reset_midsweep();
        fcw_in = 32'h1234_0000; fcw_valid = 1'b1; pho_in = 16'h0100;
        tick();
        fcw_valid = 1'b0;
        sweep_step = 32'h0001_0000; sweep_len = 16'd10; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({phase_out, phase_valid, sweep_busy, sweep_done, fcw_ready, sweep_state} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            $display("FAIL reset_midsweep: phase=%h valid=%b busy=%b done=%b ready=%b st=%0d, want 0000 0 0 0 1 0",
                     phase_out, phase_valid, sweep_busy, sweep_done, fcw_ready, sweep_state);
            miscompares++;
        end
        pho_in = 16'h0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (phase_out !== 16'h0 || sweep_busy !== 1'b0 || phase_valid !== 1'b1) begin
            $display("FAIL post_reset_fcw: phase=%h busy=%b valid=%b, want 0000 0 1", phase_out, sweep_busy, phase_valid);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_quadrant_wrap();
        test_offset_clear();
        test_sweep();
        test_load_wins();
        test_sweep_freeze();
        test_reset_midsweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
